ps2_scan_decoder: RTL and testbench

Parametrised PS/2 Set-2 scan-code decoder between the PS/2 byte receiver and keyboard consumers (key-state logic, text entry). It takes received bytes with their one-cycle done strobe and resolves E0 extended and F0 break prefixes into complete make/break events. It drops keyboard housekeeping bytes, aborts stale prefix sequences on a timeout, and buffers decoded events in a show-ahead FIFO with pop handshake and overflow flag.

---
 rtl/ps2_scan_decoder_if.sv | 24 ++
 rtl/ps2_scan_decoder.sv | 190 +++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_decoder_if.sv
// Bus between the PS/2 byte receiver / event consumer and the scan-code decoder.
interface ps2_scan_decoder_if;
  logic [7:0] codigo_tecla;
  logic       ready;
  logic       ev_pop;
  logic       overflow_clr;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_released;
  logic       key_release;
  logic       prefix_abort;
  logic       overflow;

  modport master (
    output codigo_tecla, ready, ev_pop, overflow_clr,
    input  ev_valid, ev_code, ev_ext, ev_released, key_release, prefix_abort, overflow
  );

  modport slave (
    input  codigo_tecla, ready, ev_pop, overflow_clr,
    output ev_valid, ev_code, ev_ext, ev_released, key_release, prefix_abort, overflow
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 decoder: E0/F0 prefix resolution, prefix timeout, show-ahead event FIFO.
// Optional typematic-repeat suppression when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               reset,
  ps2_scan_decoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_e;

  typedef struct packed {
    logic       ext;
    logic       released;
    logic [7:0] code;
  } event_t;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          emit, emit_ext, emit_rel, abort_d;
  logic          is_hk, is_e0, is_f0;

  assign is_e0 = (bus.codigo_tecla == 8'hE0);
  assign is_f0 = (bus.codigo_tecla == 8'hF0);
  assign is_hk = bus.codigo_tecla inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_rel = 1'b0;
    abort_d  = 1'b0;
    if (bus.ready && !is_hk) begin
      timer_d = '0;
      unique case (state_q)
        IDLE: begin
          if (is_e0)      state_d = GOT_E0;
          else if (is_f0) state_d = GOT_F0;
          else            emit    = 1'b1;
        end
        GOT_E0: begin
          if (is_f0) state_d = GOT_E0F0;
          else if (!is_e0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        GOT_F0: begin
          if (is_e0) state_d = GOT_E0F0;
          else if (!is_f0) begin
            emit     = 1'b1;
            emit_rel = 1'b1;
            state_d  = IDLE;
          end
        end
        GOT_E0F0: begin
          if (!is_e0 && !is_f0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_rel = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (!bus.ready && state_q != IDLE) begin
      if (timer_q == TLAST) begin
        state_d = IDLE;
        timer_d = '0;
        abort_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Decoded event is staged one cycle before it reaches the FIFO.
  logic   dec_vld_q, key_release_q, prefix_abort_q;
  event_t dec_ev_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      dec_vld_q      <= 1'b0;
      dec_ev_q       <= '0;
      key_release_q  <= 1'b0;
      prefix_abort_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      dec_vld_q      <= emit;
      dec_ev_q       <= '{ext: emit_ext, released: emit_rel, code: bus.codigo_tecla};
      key_release_q  <= dec_vld_q && dec_ev_q.released;
      prefix_abort_q <= abort_d;
    end
  end

  logic push_req;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held_q, held_d;
  logic       held_vld_q, held_vld_d;
  logic       suppress;
  logic       same_key;

  assign same_key = held_vld_q && (held_q == {dec_ev_q.ext, dec_ev_q.code});

  always_comb begin
    held_d     = held_q;
    held_vld_d = held_vld_q;
    suppress   = 1'b0;
    if (dec_vld_q && !dec_ev_q.released) begin
      if (same_key) begin
        suppress = 1'b1;
      end else begin
        held_d     = {dec_ev_q.ext, dec_ev_q.code};
        held_vld_d = 1'b1;
      end
    end else if (dec_vld_q && same_key) begin
      held_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end

  assign push_req = dec_vld_q && !suppress;
`else
  assign push_req = dec_vld_q;
`endif

  event_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          ev_valid, full, pop, push;
  event_t        head;

  assign ev_valid = (count_q != '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = ev_valid && bus.ev_pop;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push_req && !push)  overflow_q <= 1'b1;
      else if (bus.overflow_clr) overflow_q <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_ev_q;
  end

  assign head             = ev_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.ev_valid     = ev_valid;
  assign bus.ev_code      = head.code;
  assign bus.ev_ext       = head.ext;
  assign bus.ev_released  = head.released;
  assign bus.key_release  = key_release_q;
  assign bus.prefix_abort = prefix_abort_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: queue-based event model plus directed literal checks.
module tb_ps2_scan_decoder;
  localparam int DEPTH = 4;
  localparam int TOUT  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ps2_scan_decoder_if bus ();

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: prefix flags, idle-cycle count, one-cycle staging, event queue.
  bit [9:0] mq[$];
  bit       e0_seen, f0_seen;
  int       idle_cnt;
  bit       pend_v;
  bit [9:0] pend;
  bit       exp_kr, exp_abort, exp_ovf;
  bit       held_v;
  bit [8:0] held;
  bit       m_pop, m_push;

  function automatic bit housekeeping(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      e0_seen = 0; f0_seen = 0; idle_cnt = 0; pend_v = 0;
      exp_kr = 0; exp_abort = 0; exp_ovf = 0; held_v = 0; held = '0;
    end else begin
      m_pop  = bus.ev_pop && mq.size() > 0;
      m_push = pend_v;
      exp_kr = pend_v && pend[8];
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (pend_v && !pend[8]) begin
        if (held_v && held == {pend[9], pend[7:0]}) m_push = 0;
        else begin held = {pend[9], pend[7:0]}; held_v = 1; end
      end else if (pend_v && held_v && held == {pend[9], pend[7:0]}) begin
        held_v = 0;
      end
`endif
      if (bus.overflow_clr) exp_ovf = 0;
      if (m_push && mq.size() >= DEPTH && !m_pop) begin m_push = 0; exp_ovf = 1; end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(pend);
      pend_v = 0;
      exp_abort = 0;
      if (bus.ready && !housekeeping(bus.codigo_tecla)) begin
        idle_cnt = 0;
        if (bus.codigo_tecla == 8'hE0) e0_seen = 1;
        else if (bus.codigo_tecla == 8'hF0) f0_seen = 1;
        else begin
          pend_v = 1;
          pend = {e0_seen, f0_seen, bus.codigo_tecla};
          e0_seen = 0; f0_seen = 0;
        end
      end else if (!bus.ready && (e0_seen || f0_seen)) begin
        idle_cnt++;
        if (idle_cnt == TOUT) begin
          e0_seen = 0; f0_seen = 0; idle_cnt = 0; exp_abort = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus pulse/pop counters.
  int kr_cnt = 0, abort_cnt = 0, pop_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      check("ev_valid", bus.ev_valid, mq.size() > 0);
      check("ev_head", {bus.ev_ext, bus.ev_released, bus.ev_code}, mq.size() > 0 ? mq[0] : 10'h0);
      check("key_release", bus.key_release, exp_kr);
      check("prefix_abort", bus.prefix_abort, exp_abort);
      check("overflow", bus.overflow, exp_ovf);
      if (bus.key_release) kr_cnt++;
      if (bus.prefix_abort) abort_cnt++;
      if (bus.ev_valid && bus.ev_pop) pop_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    bus.codigo_tecla = b;
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
  endtask

  task automatic pop1();
    bus.ev_pop = 1'b1;
    tick(1);
    bus.ev_pop = 1'b0;
  endtask

  function automatic logic [31:0] head_word();
    return {22'h0, bus.ev_ext, bus.ev_released, bus.ev_code};
  endfunction

  int kr0, ab0, pc0;

  initial begin
    bus.codigo_tecla = 8'h00;
    bus.ready = 1'b0;
    bus.ev_pop = 1'b0;
    bus.overflow_clr = 1'b0;
    #2 reset = 1'b1;
    tick(2);
    check("rst_valid", bus.ev_valid, 0);
    check("rst_head", head_word(), 0);
    check("rst_pulses", {bus.key_release, bus.prefix_abort, bus.overflow}, 0);
    reset = 1'b0;

    // Make then break of 0x1C, back-to-back bytes.
    kr0 = kr_cnt;
    send(8'h1C); send(8'hF0); send(8'h1C);
    tick(3);
    check("mk_1c", head_word(), 10'h01C);
    check("kr_once", kr_cnt - kr0, 1);
    pop1();
    check("brk_1c", head_word(), 10'h11C);
    pop1();
    check("empty1", bus.ev_valid, 0);

    // Extended make/break, then the same with housekeeping bytes interleaved.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    tick(2);
    check("ext_mk", head_word(), 10'h275);
    pop1();
    check("ext_brk", head_word(), 10'h375);
    pop1();
    send(8'hE0); send(8'hFA); send(8'h75);
    send(8'hE0); send(8'hAA); send(8'hF0); send(8'hFA); send(8'h75);
    tick(2);
    check("hk_mk", head_word(), 10'h275);
    pop1();
    check("hk_brk", head_word(), 10'h375);
    pop1();

    // Prefix timeout, then a byte landing exactly on the expiry cycle.
    ab0 = abort_cnt;
    send(8'hE0);
    tick(TOUT - 1);
    check("abort_early", bus.prefix_abort, 0);
    tick(1);
    check("abort_pulse", bus.prefix_abort, 1);
    send(8'h1C);
    tick(2);
    check("post_abort", head_word(), 10'h01C);
    pop1();
    send(8'hE0);
    tick(TOUT - 1);
    send(8'h75);
    tick(2);
    check("expiry_byte", head_word(), 10'h275);
    check("abort_count", abort_cnt - ab0, 1);
    pop1();

    // Overflow: five makes into four entries, then push-while-full with pop.
    send(8'h1C); send(8'h1D); send(8'h1E); send(8'h1F); send(8'h20);
    tick(2);
    check("ovf_set", bus.overflow, 1);
    check("ovf_head", head_word(), 10'h01C);
    send(8'h21);
    pop1();
    check("full_pop_head", head_word(), 10'h01D);
    check("ovf_kept", bus.overflow, 1);
    bus.overflow_clr = 1'b1;
    tick(1);
    bus.overflow_clr = 1'b0;
    check("ovf_clr", bus.overflow, 0);
    pop1(); pop1(); pop1();
    check("last_entry", head_word(), 10'h021);
    pop1();
    check("empty2", bus.ev_valid, 0);

    // Typematic repeats with a consumer popping continuously.
    pc0 = pop_cnt;
    bus.ev_pop = 1'b1;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    tick(4);
    bus.ev_pop = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("typematic_events", pop_cnt - pc0, 3);
`else
    check("typematic_events", pop_cnt - pc0, 5);
`endif

    // Reset in GOT_E0F0 with two events queued.
    send(8'h1C); send(8'h1D); send(8'hE0); send(8'hF0);
    check("pre_reset_valid", bus.ev_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", bus.ev_valid, 0);
    check("mid_rst_head", head_word(), 0);
    check("mid_rst_flags", {bus.key_release, bus.prefix_abort, bus.overflow}, 0);
    tick(1);
    reset = 1'b0;
    send(8'h1C);
    tick(2);
    check("post_rst_make", head_word(), 10'h01C);
    pop1();
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
